// File: rtl/cva6_cfg_descriptor.sv
// Descriptor map of the elaborated CVA6 configuration: one-cycle read port plus a backpressured dump stream.
// Optional trailing XOR checksum beat is built when CVA6_CFG_DESC_CHECKSUM_EN is defined.

package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        bit          RVA;
        bit          RVB;
        bit          RVC;
        bit          RVD;
        bit          RVF;
        bit          RVH;
        bit          RVS;
        bit          RVU;
        bit          RVV;
        bit          RVZCB;
        bit          RVZCMP;
        bit          RVZiCond;
        bit          CvxifEn;
        bit          MmuPresent;
        bit          DebugEn;
        bit          PerfCounterEn;
        int unsigned NrCommitPorts;
        int unsigned NrScoreboardEntries;
        int unsigned NrPMPEntries;
        int unsigned RASDepth;
        int unsigned NrLoadBufEntries;
        int unsigned MaxOutstandingStores;
        int unsigned DCacheType;
        int unsigned IcacheByteSize;
        int unsigned IcacheSetAssoc;
        int unsigned IcacheLineWidth;
        int unsigned DcacheByteSize;
        int unsigned DcacheSetAssoc;
        int unsigned DcacheLineWidth;
        int unsigned BTBEntries;
        int unsigned BHTEntries;
        int unsigned InstrTlbEntries;
        int unsigned DataTlbEntries;
        logic [63:0] HaltAddress;
        logic [63:0] ExceptionAddress;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// state  | meaning
// IDLE   | no dump in progress, waiting for dump_start_i
// STREAM | presenting descriptor word idx, advancing on each accepted beat
// CHKSUM | presenting the XOR of all streamed words (checksum build only)
module cva6_cfg_descriptor #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NrWords = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [3:0]  addr_i,
    output logic        rvalid_o,
    output logic [63:0] rdata_o,
    output logic        rerr_o,
    input  logic        dump_start_i,
    output logic        dump_valid_o,
    output logic [63:0] dump_data_o,
    output logic        dump_last_o,
    input  logic        dump_ready_i,
    output logic        dump_busy_o
);

    localparam int unsigned IdxW = $clog2(NrWords);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NrWords - 1);

    localparam logic [63:0] Word0 = 64'h4356_4136_0000_0001;

    localparam logic [63:0] Word1 = {
        25'b0,
        CVA6Cfg.PerfCounterEn, CVA6Cfg.DebugEn, CVA6Cfg.MmuPresent, CVA6Cfg.CvxifEn,
        CVA6Cfg.RVZiCond, CVA6Cfg.RVZCMP, CVA6Cfg.RVZCB,
        10'b0,
        CVA6Cfg.RVV, CVA6Cfg.RVU, 1'b0, CVA6Cfg.RVS,
        5'b0,
        1'b1,
        3'b0,
        1'b1,
        CVA6Cfg.RVH, 1'b0, CVA6Cfg.RVF, 1'b0,
        CVA6Cfg.RVD, CVA6Cfg.RVC, CVA6Cfg.RVB, CVA6Cfg.RVA
    };

    localparam logic [63:0] Word2 = {
        6'b0,
        2'(CVA6Cfg.DCacheType),
        8'(CVA6Cfg.MaxOutstandingStores),
        8'(CVA6Cfg.NrLoadBufEntries),
        8'(CVA6Cfg.RASDepth),
        8'(CVA6Cfg.NrPMPEntries),
        8'(CVA6Cfg.NrScoreboardEntries),
        8'(CVA6Cfg.NrCommitPorts),
        8'(CVA6Cfg.XLEN)
    };

    localparam logic [63:0] Word3 = {
        8'b0,
        16'(CVA6Cfg.IcacheLineWidth),
        8'(CVA6Cfg.IcacheSetAssoc),
        32'(CVA6Cfg.IcacheByteSize)
    };

    localparam logic [63:0] Word4 = {
        8'b0,
        16'(CVA6Cfg.DcacheLineWidth),
        8'(CVA6Cfg.DcacheSetAssoc),
        32'(CVA6Cfg.DcacheByteSize)
    };

    localparam logic [63:0] Word5 = {
        16'(CVA6Cfg.DataTlbEntries),
        16'(CVA6Cfg.InstrTlbEntries),
        16'(CVA6Cfg.BHTEntries),
        16'(CVA6Cfg.BTBEntries)
    };

    localparam logic [63:0] Word6 = CVA6Cfg.HaltAddress;
    localparam logic [63:0] Word7 = CVA6Cfg.ExceptionAddress;

    function automatic logic [63:0] word_at(input logic [3:0] idx);
        logic [63:0] w;
        w = '0;
        case (idx)
            4'd0:    w = Word0;
            4'd1:    w = Word1;
            4'd2:    w = Word2;
            4'd3:    w = Word3;
            4'd4:    w = Word4;
            4'd5:    w = Word5;
            4'd6:    w = Word6;
            4'd7:    w = Word7;
            default: w = '0;
        endcase
        return w;
    endfunction

    // Read port: fully independent of the dump machinery.
    logic        rvalid_q;
    logic [63:0] rdata_q;
    logic        rerr_q;
    logic        addr_ok;

    assign addr_ok = (addr_i < 4'(NrWords));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            rvalid_q <= req_i;
            rdata_q  <= (req_i && addr_ok) ? word_at(addr_i) : '0;
            rerr_q   <= req_i && !addr_ok;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign rerr_o   = rerr_q;

    typedef enum logic [1:0] {
        IDLE,
        STREAM
`ifdef CVA6_CFG_DESC_CHECKSUM_EN
        , CHKSUM
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
`ifdef CVA6_CFG_DESC_CHECKSUM_EN
    logic [63:0]     acc_q, acc_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
`ifdef CVA6_CFG_DESC_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
`ifdef CVA6_CFG_DESC_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // Outputs depend only on registered state, so they hold while stalled.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
`ifdef CVA6_CFG_DESC_CHECKSUM_EN
        acc_d        = acc_q;
`endif
        dump_valid_o = 1'b0;
        dump_data_o  = '0;
        dump_last_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (dump_start_i) begin
                    state_d = STREAM;
                    idx_d   = '0;
`ifdef CVA6_CFG_DESC_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            STREAM: begin
                dump_valid_o = 1'b1;
                dump_data_o  = word_at(4'(idx_q));
`ifndef CVA6_CFG_DESC_CHECKSUM_EN
                dump_last_o  = (idx_q == LastIdx);
`endif
                if (dump_ready_i) begin
                    idx_d = idx_q + 1'b1;
`ifdef CVA6_CFG_DESC_CHECKSUM_EN
                    acc_d = acc_q ^ dump_data_o;
                    if (idx_q == LastIdx) state_d = CHKSUM;
`else
                    if (idx_q == LastIdx) state_d = IDLE;
`endif
                end
            end
`ifdef CVA6_CFG_DESC_CHECKSUM_EN
            CHKSUM: begin
                dump_valid_o = 1'b1;
                dump_data_o  = acc_q;
                dump_last_o  = 1'b1;
                if (dump_ready_i) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign dump_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_cva6_cfg_descriptor.sv
// Directed bench for cva6_cfg_descriptor using a cv64a6_imafdch_sv39-style configuration.
// Expected beat count follows CVA6_CFG_DESC_CHECKSUM_EN.
module tb_cva6_cfg_descriptor;

    localparam config_pkg::cva6_cfg_t Cfg = '{
        XLEN: 64,
        RVA: 1'b1, RVB: 1'b1, RVC: 1'b1, RVD: 1'b1, RVF: 1'b1, RVH: 1'b1,
        RVS: 1'b1, RVU: 1'b1, RVV: 1'b0,
        RVZCB: 1'b1, RVZCMP: 1'b0, RVZiCond: 1'b1, CvxifEn: 1'b1,
        MmuPresent: 1'b1, DebugEn: 1'b1, PerfCounterEn: 1'b1,
        NrCommitPorts: 2, NrScoreboardEntries: 8, NrPMPEntries: 8, RASDepth: 2,
        NrLoadBufEntries: 2, MaxOutstandingStores: 7, DCacheType: 1,
        IcacheByteSize: 16384, IcacheSetAssoc: 4, IcacheLineWidth: 128,
        DcacheByteSize: 32768, DcacheSetAssoc: 8, DcacheLineWidth: 128,
        BTBEntries: 32, BHTEntries: 128, InstrTlbEntries: 16, DataTlbEntries: 16,
        HaltAddress: 64'h800, ExceptionAddress: 64'h808
    };

`ifdef CVA6_CFG_DESC_CHECKSUM_EN
    localparam int NBeats = 9;
`else
    localparam int NBeats = 8;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [3:0]  addr_i;
    logic        rvalid_o;
    logic [63:0] rdata_o;
    logic        rerr_o;
    logic        dump_start_i;
    logic        dump_valid_o;
    logic [63:0] dump_data_o;
    logic        dump_last_o;
    logic        dump_ready_i;
    logic        dump_busy_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_w [9];

    cva6_cfg_descriptor #(.CVA6Cfg(Cfg), .NrWords(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .rerr_o      (rerr_o),
        .dump_start_i(dump_start_i),
        .dump_valid_o(dump_valid_o),
        .dump_data_o (dump_data_o),
        .dump_last_o (dump_last_o),
        .dump_ready_i(dump_ready_i),
        .dump_busy_o (dump_busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
        check({tag, "_rdata"}, rdata_o, 64'd0);
        check({tag, "_rerr"}, 64'(rerr_o), 64'd0);
        check({tag, "_dvalid"}, 64'(dump_valid_o), 64'd0);
        check({tag, "_ddata"}, dump_data_o, 64'd0);
        check({tag, "_dlast"}, 64'(dump_last_o), 64'd0);
        check({tag, "_busy"}, 64'(dump_busy_o), 64'd0);
    endtask

    // Runs one complete dump; optionally stalls with ready pattern 1,0,0,1 and
    // optionally fires a second start plus a read of word 5 after beat 2 is accepted.
    task automatic run_dump(input string tag, input bit stall, input bit inject);
        logic [63:0] got_q[$];
        bit          last_q[$];
        logic [63:0] held;
        bit          held_last;
        bit          holding;
        bit          read_pending;
        logic [3:0]  pat;
        int          cyc;
        pat          = 4'b1001;
        holding      = 1'b0;
        held         = '0;
        held_last    = 1'b0;
        read_pending = 1'b0;
        cyc          = 0;

        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        check({tag, "_start_valid"}, 64'(dump_valid_o), 64'd1);
        check({tag, "_start_busy"}, 64'(dump_busy_o), 64'd1);

        while (got_q.size() < NBeats && cyc < 200) begin
            dump_ready_i = stall ? pat[cyc % 4] : 1'b1;
            if (read_pending) begin
                check({tag, "_inj_rvalid"}, 64'(rvalid_o), 64'd1);
                check({tag, "_inj_rdata"}, rdata_o, exp_w[5]);
                check({tag, "_inj_rerr"}, 64'(rerr_o), 64'd0);
                req_i        = 1'b0;
                dump_start_i = 1'b0;
                read_pending = 1'b0;
            end
            if (holding) begin
                check({tag, "_stall_data"}, dump_data_o, held);
                check({tag, "_stall_last"}, 64'(dump_last_o), 64'(held_last));
            end
            if (!stall) check({tag, "_no_bubble"}, 64'(dump_valid_o), 64'd1);
            if (dump_valid_o && dump_ready_i) begin
                got_q.push_back(dump_data_o);
                last_q.push_back(dump_last_o);
                holding = 1'b0;
                if (inject && got_q.size() == 3) begin
                    dump_start_i = 1'b1;
                    req_i        = 1'b1;
                    addr_i       = 4'd5;
                    read_pending = 1'b1;
                end
                // a start coinciding with the final acceptance must be ignored
                if (got_q.size() == NBeats) dump_start_i = 1'b1;
            end else if (dump_valid_o) begin
                holding   = 1'b1;
                held      = dump_data_o;
                held_last = dump_last_o;
            end
            tick();
            cyc++;
        end
        dump_start_i = 1'b0;
        dump_ready_i = 1'b0;

        check({tag, "_beat_count"}, 64'(got_q.size()), 64'(NBeats));
        for (int b = 0; b < got_q.size(); b++) begin
            check($sformatf("%s_beat%0d", tag, b), got_q[b], exp_w[b]);
            check($sformatf("%s_last%0d", tag, b), 64'(last_q[b]), 64'(b == NBeats - 1));
        end
        check({tag, "_busy_fall"}, 64'(dump_busy_o), 64'd0);
        check({tag, "_valid_fall"}, 64'(dump_valid_o), 64'd0);
        tick();
        check({tag, "_late_start_ignored"}, 64'(dump_busy_o), 64'd0);
    endtask

    initial begin
        int rd_addr [10];
        logic [63:0] exp_rd;
        rd_addr = '{0, 1, 6, 7, 2, 3, 4, 5, 9, 15};

        exp_w[0] = 64'h4356_4136_0000_0001;
        exp_w[1] = 64'h0000_007D_0014_11AF;
        exp_w[2] = 64'h0107_0202_0808_0240;
        exp_w[3] = 64'h0000_8004_0000_4000;
        exp_w[4] = 64'h0000_8008_0000_8000;
        exp_w[5] = 64'h0010_0010_0080_0020;
        exp_w[6] = 64'h0000_0000_0000_0800;
        exp_w[7] = 64'h0000_0000_0000_0808;
        exp_w[8] = '0;
        for (int i = 0; i < 8; i++) exp_w[8] = exp_w[8] ^ exp_w[i];

        rst_i        = 1'b1;
        req_i        = 1'b0;
        addr_i       = '0;
        dump_start_i = 1'b0;
        dump_ready_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;
        check_all_zero("reset");

        // back-to-back reads, including out-of-range indices
        for (int i = 0; i < 10; i++) begin
            req_i  = 1'b1;
            addr_i = 4'(rd_addr[i]);
            tick();
            exp_rd = (rd_addr[i] < 8) ? exp_w[rd_addr[i]] : 64'd0;
            check($sformatf("rd_valid_a%0d", rd_addr[i]), 64'(rvalid_o), 64'd1);
            check($sformatf("rd_data_a%0d", rd_addr[i]), rdata_o, exp_rd);
            check($sformatf("rd_err_a%0d", rd_addr[i]), 64'(rerr_o), 64'(rd_addr[i] >= 8));
        end
        req_i = 1'b0;
        tick();
        check("rd_idle_valid", 64'(rvalid_o), 64'd0);
        check("rd_idle_err", 64'(rerr_o), 64'd0);

        run_dump("full", 1'b0, 1'b0);
        run_dump("stall", 1'b1, 1'b0);
        run_dump("inject", 1'b0, 1'b1);

        // reset while beat 4 is presented
        dump_ready_i = 1'b1;
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check($sformatf("abort_beat%0d", b), dump_data_o, exp_w[b]);
            tick();
        end
        check("abort_beat4", dump_data_o, exp_w[4]);
        rst_i  = 1'b1;
        req_i  = 1'b1;
        addr_i = 4'd1;
        tick();
        check_all_zero("abort");
        rst_i        = 1'b0;
        req_i        = 1'b0;
        dump_ready_i = 1'b0;
        tick();
        check("abort_idle_busy", 64'(dump_busy_o), 64'd0);
        run_dump("restart", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
